// File: rtl/catc_exec_unit.sv
// CATC execution unit: handshaked single-instruction executor over a local register file and scratch memory.
// Optional iterative multiplier for opcode B is built when CATC_MUL_EN is defined.
//
// state | meaning
// INIT  | clearing scratch memory, one word per cycle
// IDLE  | instr_ready high, waiting for an instruction
// EXEC  | decode, compute, writeback, register outputs
// MULT  | shift-add multiply, one multiplier bit per cycle (CATC_MUL_EN only)
// RESP  | out_valid high, outputs held until out_ready
module catc_exec_unit #(
    parameter int DATA_W    = 20,
    parameter int REG_N     = 16,
    parameter int IMM_W     = 8,
    parameter int MEM_DEPTH = 128,
    localparam int RA_W     = $clog2(REG_N),
    localparam int MA_W     = $clog2(MEM_DEPTH),
    localparam int INSTR_W  = 4 + 2*RA_W + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out,
    output logic               out_carry,
    output logic               out_err
);

`ifdef CATC_MUL_EN
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_EXEC, S_MULT, S_RESP} state_t;
    localparam int MC_W = $clog2(DATA_W);
`else
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_t;
`endif

    state_t              state_q, state_d;
    logic [MA_W-1:0]     init_cnt_q, init_cnt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                carry_q, carry_d;
    logic                err_q, err_d;
    logic                instr_ready_q, instr_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [DATA_W-1:0]   regs_q [REG_N];
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic                rf_we;
    logic [RA_W-1:0]     rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic                mem_we;
    logic [MA_W-1:0]     mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic [3:0]          opc;
    logic [RA_W-1:0]     src, dest;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   imm_ext, rs, rd;
    logic [DATA_W:0]     addi_w, subi_w, add_w;

    assign opc     = instr_q[INSTR_W-1 -: 4];
    assign src     = instr_q[IMM_W+RA_W +: RA_W];
    assign dest    = instr_q[IMM_W +: RA_W];
    assign imm     = instr_q[IMM_W-1:0];
    assign imm_ext = DATA_W'(imm);
    assign rs      = regs_q[src];
    assign rd      = regs_q[dest];

    // The extra top bit is the carry for sums and the borrow for the difference.
    assign addi_w = {1'b0, opnd_q} + {1'b0, imm_ext};
    assign subi_w = {1'b0, opnd_q} - {1'b0, imm_ext};
    assign add_w  = {1'b0, rs} + {1'b0, rd};

`ifdef CATC_MUL_EN
    logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_nxt;
    logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;

    assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        instr_d    = instr_q;
        opnd_d     = opnd_q;
        data_out_d = data_out_q;
        carry_d    = carry_q;
        err_d      = err_q;
        rf_we      = 1'b0;
        rf_wa      = dest;
        rf_wd      = '0;
        mem_we     = 1'b0;
        mem_wa     = imm[MA_W-1:0];
        mem_wd     = rs;
`ifdef CATC_MUL_EN
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_cnt_d  = mul_cnt_q;
`endif
        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = init_cnt_q;
                mem_wd = '0;
                if (init_cnt_q == '0) state_d = S_IDLE;
                else                  init_cnt_d = init_cnt_q - 1'b1;
            end
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    opnd_d  = data_in;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                carry_d = 1'b0;
                err_d   = 1'b0;
                case (opc)
                    4'h0: data_out_d = rs;
                    4'h1: begin
                        data_out_d = opnd_q;
                        rf_we      = 1'b1;
                        rf_wd      = opnd_q;
                    end
                    4'h2: {carry_d, data_out_d} = addi_w;
                    4'h3: {carry_d, data_out_d} = subi_w;
                    4'h4: data_out_d = rs & rd;
                    4'h5: data_out_d = rs | rd;
                    4'h6: data_out_d = rs ^ rd;
                    4'h7: data_out_d = ~opnd_q;
                    4'h8: data_out_d = mem_q[imm[MA_W-1:0]];
                    4'h9: begin
                        data_out_d = rs;
                        mem_we     = 1'b1;
                    end
                    4'hA: begin
                        {carry_d, data_out_d} = add_w;
                        rf_we = 1'b1;
                        rf_wd = add_w[DATA_W-1:0];
                    end
`ifdef CATC_MUL_EN
                    4'hB: begin
                        mcand_d   = rs;
                        mplier_d  = rd;
                        acc_d     = '0;
                        mul_cnt_d = MC_W'(DATA_W-1);
                        state_d   = S_MULT;
                    end
`endif
                    default: begin
                        data_out_d = '0;
                        err_d      = 1'b1;
                    end
                endcase
            end
`ifdef CATC_MUL_EN
            S_MULT: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (mul_cnt_q == '0) begin
                    state_d    = S_RESP;
                    data_out_d = acc_nxt;
                    rf_we      = 1'b1;
                    rf_wd      = acc_nxt;
                end else begin
                    mul_cnt_d = mul_cnt_q - 1'b1;
                end
            end
`endif
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
        instr_ready_d = (state_d == S_IDLE);
        out_valid_d   = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            init_cnt_q    <= MA_W'(MEM_DEPTH-1);
            instr_q       <= '0;
            opnd_q        <= '0;
            data_out_q    <= '0;
            carry_q       <= 1'b0;
            err_q         <= 1'b0;
            instr_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
`ifdef CATC_MUL_EN
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            mul_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            instr_q       <= instr_d;
            opnd_q        <= opnd_d;
            data_out_q    <= data_out_d;
            carry_q       <= carry_d;
            err_q         <= err_d;
            instr_ready_q <= instr_ready_d;
            out_valid_q   <= out_valid_d;
            if (rf_we) regs_q[rf_wa] <= rf_wd;
`ifdef CATC_MUL_EN
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            mul_cnt_q     <= mul_cnt_d;
`endif
        end
    end

    // Scratch memory has no reset; INIT clears it after every reset instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign instr_ready = instr_ready_q;
    assign out_valid   = out_valid_q;
    assign data_out    = data_out_q;
    assign out_carry   = carry_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_catc_exec_unit.sv
// Self-checking bench for catc_exec_unit: directed steps plus randomized instructions
// checked against an arithmetic reference model of registers and scratch memory.
module tb_catc_exec_unit;
    localparam int DATA_W    = 20;
    localparam int REG_N     = 16;
    localparam int IMM_W     = 8;
    localparam int MEM_DEPTH = 128;
    localparam int INSTR_W   = 20;
    localparam longint MASK  = (64'd1 << DATA_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               instr_valid = 1'b0;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr = '0;
    logic [DATA_W-1:0]  data_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  data_out;
    logic               out_carry;
    logic               out_err;

    int n_total = 0;
    int n_pass  = 0;

    longint ref_regs [REG_N];
    longint ref_mem  [MEM_DEPTH];

    catc_exec_unit dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_carry(out_carry), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < REG_N; i++) ref_regs[i] = 0;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 0;
    endtask

    task automatic ref_exec(input int op, input int src, input int dest, input int imm,
                            input longint din, output longint res, output bit c, output bit e);
        longint t;
        res = 0; c = 0; e = 0;
        case (op)
            0: res = ref_regs[src];
            1: begin ref_regs[dest] = din; res = din; end
            2: begin t = din + imm; res = t & MASK; c = (t > MASK); end
            3: begin res = (din - imm) & MASK; c = (din < imm); end
            4: res = ref_regs[src] & ref_regs[dest];
            5: res = ref_regs[src] | ref_regs[dest];
            6: res = ref_regs[src] ^ ref_regs[dest];
            7: res = (~din) & MASK;
            8: res = ref_mem[imm % MEM_DEPTH];
            9: begin ref_mem[imm % MEM_DEPTH] = ref_regs[src]; res = ref_regs[src]; end
            10: begin
                t = ref_regs[src] + ref_regs[dest];
                res = t & MASK; c = (t > MASK); ref_regs[dest] = res;
            end
`ifdef CATC_MUL_EN
            11: begin res = (ref_regs[src] * ref_regs[dest]) & MASK; ref_regs[dest] = res; end
`endif
            default: begin res = 0; e = 1; end
        endcase
    endtask

    // rst must already be high on entry; checks reset outputs then times the memory clear.
    task automatic reset_seq(input string tag);
        int n;
        #1;
        chk({tag, "_rst_ready"}, instr_ready, 0);
        chk({tag, "_rst_valid"}, out_valid, 0);
        chk({tag, "_rst_data"}, data_out, 0);
        chk({tag, "_rst_carry"}, out_carry, 0);
        chk({tag, "_rst_err"}, out_err, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (instr_ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_init_cycles"}, n, MEM_DEPTH);
    endtask

    task automatic do_op(input int op, input int src, input int dest, input int imm,
                         input longint din, input int hold, input string tag);
        longint e_res;
        bit     e_c, e_e;
        int     k, lat, e_lat;
        ref_exec(op, src, dest, imm, din, e_res, e_c, e_e);
        e_lat = 2;
`ifdef CATC_MUL_EN
        if (op == 11) e_lat = DATA_W + 2;
`endif
        @(negedge clk);
        instr       = {op[3:0], src[3:0], dest[3:0], imm[7:0]};
        data_in     = din[DATA_W-1:0];
        instr_valid = 1'b1;
        out_ready   = 1'b0;
        k = 0;
        while (instr_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_accept"}, instr_ready, 1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, e_lat);
        repeat (hold) @(negedge clk);
        if (hold > 0) chk({tag, "_held_ready"}, instr_ready, 0);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, data_out, e_res);
        chk({tag, "_carry"}, out_carry, e_c);
        chk({tag, "_err"}, out_err, e_e);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        reset_seq("por");

        do_op(8, 0, 0, 5, 0, 0, "ldm_clear");
        do_op(1, 0, 3, 0, 64'h12345, 0, "wreg3");
        do_op(0, 3, 0, 0, 0, 0, "movr3");
        do_op(2, 0, 0, 1, 64'hFFFFF, 0, "addi_wrap");
        do_op(3, 0, 0, 1, 0, 0, "subi_borrow");
        do_op(9, 3, 0, 8'h85, 0, 0, "stm_wrap");
        do_op(8, 0, 0, 8'h05, 0, 0, "ldm_wrap");
        do_op(14, 3, 3, 8'hFF, 64'h55555, 0, "illegal_e");
        do_op(0, 3, 0, 0, 0, 10, "resp_hold");
        do_op(1, 0, 1, 0, 7, 0, "wreg1");
        do_op(1, 0, 2, 0, 6, 0, "wreg2");
        do_op(11, 1, 2, 0, 0, 0, "mul");
        do_op(0, 2, 0, 0, 0, 0, "movr2");
        do_op(10, 3, 3, 0, 0, 0, "add_double");
        do_op(7, 0, 0, 0, 64'h0F0F0, 0, "not");

        // Reset right after an accept: the instruction must vanish and memory be re-cleared.
        @(negedge clk);
        instr       = {4'h1, 4'h0, 4'h5, 8'h00};
        data_in     = 20'hABCDE;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        rst = 1'b1;
        reset_seq("midop");
        do_op(0, 5, 0, 0, 0, 0, "midop_r5");
        do_op(8, 0, 0, 5, 0, 0, "midop_mem5");

        for (int i = 0; i < 80; i++) begin
            do_op($urandom_range(0, 15), $urandom_range(0, REG_N-1), $urandom_range(0, REG_N-1),
                  $urandom_range(0, 255), longint'($urandom) & MASK, $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
